mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the core's instruction-fetch port
//  and its load/store port. Arbitrates requests, sequences the memory access over
//  MEM_LAT wait cycles, and returns the registered response to the owning requester.
//  Sits between the core and a synchronous-read memory; enables the multi-cycle core.
// PARAMETERS
//  AW          32  address width (byte address)
//  DW          32  data width
//  MEM_LAT     1   cycles from mem_en to valid mem_rdata (>=1)
//  STARVE_MAX  4   consecutive ls wins while fetch waits before fetch is forced
// PORTS
//  clk           in   1    clock
//  rst           in   1    reset, synchronous, active-high
//  if_req_valid  in   1    fetch request
//  if_req_ready  out  1    fetch accepted this cycle
//  if_addr       in   AW   fetch address
//  if_rsp_valid  out  1    one-cycle pulse, if_rdata valid
//  if_rdata      out  DW   fetched instruction (registered)
//  ls_req_valid  in   1    load/store request
//  ls_req_ready  out  1    load/store accepted this cycle
//  ls_addr       in   AW   load/store address
//  ls_we         in   1    1=store, 0=load
//  ls_wstrb      in   DW/8 store byte enables
//  ls_wdata      in   DW   store data
//  ls_rsp_valid  out  1    one-cycle pulse: load data valid / store done
//  ls_rdata      out  DW   load data (registered; unchanged on store)
//  mem_en        out  1    memory access strobe
//  mem_we        out  1    memory write enable
//  mem_wstrb     out  DW/8 memory byte enables
//  mem_addr      out  AW   memory address
//  mem_wdata     out  DW   memory write data
//  mem_rdata     in   DW   memory read data
// BEHAVIOUR
//  - FSM IDLE -> WAIT -> IDLE. Accept only in IDLE; accept cycle T = valid & ready.
//  - Grant in IDLE (combinational): ls only -> ls; if only -> if; both -> ls unless
//    starve_cnt==STARVE_MAX, then if. Ready high only for winner, only in IDLE.
//  - At T: mem_en=1; mem_addr/we/wstrb/wdata driven from winner's inputs (fetch: we=0,
//    wstrb=0). mem_* = 0 in all other cycles. Owner is latched; state -> WAIT.
//  - WAIT lasts MEM_LAT cycles (lat counter MEM_LAT-1 down to 0). On the last edge:
//    capture mem_rdata into owner's rdata reg (loads/fetches only), set owner's
//    rsp_valid, state -> IDLE. rsp_valid high in cycle T+MEM_LAT+1 only.
//  - New accept allowed in the rsp_valid cycle; max throughput 1 per MEM_LAT+1 cycles.
//  - starve_cnt: +1 when ls granted while if_req_valid=1, saturates at STARVE_MAX;
//    cleared when fetch granted.
//  - Requesters hold valid and payload stable until ready; arbiter never drops one.
//  - Reset (any state, incl. WAIT): state=IDLE, all rsp_valid=0, rdata regs=0,
//    starve_cnt=0, lat counter=0, owner=fetch. In-flight access discarded, no response;
//    requester re-issues. All ready/mem_* outputs 0 during reset cycle.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds out ports if_grant_cnt, ls_grant_cnt, conflict_cnt
//  (32b each): +1 per fetch accept, ls accept, and IDLE cycle with both valid; wrap at
//  2^32; 0 on rst. Undefined: ports and counters absent; arbitration identical.
// TESTING
//  1 fetch 0x10, mem[0x10]=0x00500093, MEM_LAT=1 -> ready@T, mem_en@T addr 0x10 we=0;
//    if_rsp_valid@T+2 with if_rdata=0x00500093; no ls_rsp_valid.
//  2 store 0x40 data 0xDEADBEEF wstrb 0xF, then load 0x40 -> ls_rsp_valid after each;
//    load returns 0xDEADBEEF; ls_rdata unchanged by store response.
//  3 both valid every cycle, STARVE_MAX=4 -> grant order ls,ls,ls,ls,if,ls,ls,ls,ls,if.
//  4 rst=1 in WAIT cycle -> no rsp_valid next cycle, state IDLE, starve_cnt 0;
//    re-issued request completes normally.
//  5 MEM_LAT=3 single load -> readies low T+1..T+3, ls_rsp_valid@T+4 only.
//  6 ARB_PERF_CNT_EN, run scenario 3 for 10 grants -> if_grant_cnt=2, ls_grant_cnt=8,
//    conflict_cnt=10.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, synchronous-read memory between the fetch port and the
// load/store port. Define ARB_PERF_CNT_EN to add grant/conflict performance counters.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_wstrb,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_rsp_valid,
  output logic [DW-1:0]   ls_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]     if_grant_cnt,
  output logic [31:0]     ls_grant_cnt,
  output logic [31:0]     conflict_cnt,
`endif
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LW-1:0] LAT_TOP    = LW'(MEM_LAT - 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            store_q, store_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic            if_rsp_q, if_rsp_d, ls_rsp_q, ls_rsp_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic            starved, grant_ls, grant_if;

  // Load/store wins ties unless fetch has already lost STARVE_MAX times in a row.
  assign starved  = (starve_q == STARVE_TOP);
  assign grant_ls = ls_req_valid && !(if_req_valid && starved);
  assign grant_if = if_req_valid && !grant_ls;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    store_d      = store_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    if_rsp_d     = 1'b0;
    ls_rsp_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (grant_ls) begin
            ls_req_ready = 1'b1;
            mem_en       = 1'b1;
            mem_we       = ls_we;
            mem_wstrb    = ls_wstrb;
            mem_addr     = ls_addr;
            mem_wdata    = ls_wdata;
            owner_d      = OWN_LS;
            store_d      = ls_we;
            lat_d        = LAT_TOP;
            state_d      = S_WAIT;
            if (if_req_valid && !starved) starve_d = starve_q + 1'b1;
          end else if (grant_if) begin
            if_req_ready = 1'b1;
            mem_en       = 1'b1;
            mem_addr     = if_addr;
            owner_d      = OWN_IF;
            store_d      = 1'b0;
            lat_d        = LAT_TOP;
            state_d      = S_WAIT;
            starve_d     = '0;
          end
        end
        S_WAIT: begin
          if (lat_q == '0) begin
            state_d = S_IDLE;
            if (owner_q == OWN_LS) begin
              ls_rsp_d = 1'b1;
              if (!store_q) ls_rdata_d = mem_rdata;
            end else begin
              if_rsp_d   = 1'b1;
              if_rdata_d = mem_rdata;
            end
          end else begin
            lat_d = lat_q - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      store_q    <= 1'b0;
      lat_q      <= '0;
      starve_q   <= '0;
      if_rsp_q   <= 1'b0;
      ls_rsp_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      store_q    <= store_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      if_rsp_q   <= if_rsp_d;
      ls_rsp_q   <= ls_rsp_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_rsp_valid = if_rsp_q;
  assign if_rdata     = if_rdata_q;
  assign ls_rsp_valid = ls_rsp_q;
  assign ls_rdata     = ls_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_grant_cnt_q, ls_grant_cnt_q, conflict_cnt_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_grant_cnt_q <= '0;
      ls_grant_cnt_q <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (if_req_ready) if_grant_cnt_q <= if_grant_cnt_q + 32'd1;
      if (ls_req_ready) ls_grant_cnt_q <= ls_grant_cnt_q + 32'd1;
      if (state_q == S_IDLE && if_req_valid && ls_req_valid)
        conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign if_grant_cnt = if_grant_cnt_q;
  assign ls_grant_cnt = ls_grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked every cycle against
// a transaction-level model (busy window, response schedule, reference memory).
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic        clk, rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
  logic [3:0]  ls_wstrb;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_grant_cnt, ls_grant_cnt, conflict_cnt;
`endif

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
`ifdef ARB_PERF_CNT_EN
    .if_grant_cnt(if_grant_cnt), .ls_grant_cnt(ls_grant_cnt), .conflict_cnt(conflict_cnt),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit if_acc, ls_acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h0050_0093 : 32'h1000_0000 + 32'(i);
  endfunction

  // Synchronous-read memory: read data appears LAT cycles after the mem_en cycle.
  logic [31:0] mem [64];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'hBAD0_0000;
    forever begin
      @(posedge clk);
      for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= mem_en ? mem[mem_addr[7:2]] : 32'hBAD0_0000;
      if (mem_en && mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model: a request is accepted only when the arbiter is free; each accepted access
  // schedules one response LAT+1 cycles later carrying the reference memory contents.
  typedef struct {
    int          at;
    bit          ls;
    bit          load;
    logic [31:0] data;
  } rsp_t;

  initial begin
    rsp_t        rq[$];
    rsp_t        r;
    logic [31:0] ref_mem [64];
    logic [31:0] e_if_rdata, e_ls_rdata;
    logic [31:0] m_ifg, m_lsg, m_conf;
    bit          e_if_rsp, e_ls_rsp, idle, gl, gi, armed;
    int          free_at, starve;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    e_if_rdata = '0; e_ls_rdata = '0;
    m_ifg = '0; m_lsg = '0; m_conf = '0;
    armed = 1'b0; free_at = 0; starve = 0;
    forever begin
      @(negedge clk);
      e_if_rsp = 1'b0;
      e_ls_rsp = 1'b0;
      if (rq.size() > 0 && rq[0].at == cyc) begin
        r = rq.pop_front();
        if (r.ls) begin
          e_ls_rsp = 1'b1;
          if (r.load) e_ls_rdata = r.data;
        end else begin
          e_if_rsp   = 1'b1;
          e_if_rdata = r.data;
        end
      end
      idle = !rst && (cyc >= free_at);
      gl   = idle && ls_req_valid && !(if_req_valid && starve == SMAX);
      gi   = idle && if_req_valid && !gl;
      if (armed) begin
        check("if_req_ready", if_req_ready, gi);
        check("ls_req_ready", ls_req_ready, gl);
        check("mem_en", mem_en, gi || gl);
        check("mem_addr", mem_addr, gl ? ls_addr : (gi ? if_addr : 32'h0));
        check("mem_we", mem_we, gl && ls_we);
        check("mem_wstrb", mem_wstrb, gl ? ls_wstrb : 4'h0);
        if (!gi) check("mem_wdata", mem_wdata, gl ? ls_wdata : 32'h0);
        check("if_rsp_valid", if_rsp_valid, e_if_rsp);
        check("ls_rsp_valid", ls_rsp_valid, e_ls_rsp);
        check("if_rdata", if_rdata, e_if_rdata);
        check("ls_rdata", ls_rdata, e_ls_rdata);
`ifdef ARB_PERF_CNT_EN
        check("if_grant_cnt", if_grant_cnt, m_ifg);
        check("ls_grant_cnt", ls_grant_cnt, m_lsg);
        check("conflict_cnt", conflict_cnt, m_conf);
`endif
      end
      if_acc = if_req_valid && if_req_ready;
      ls_acc = ls_req_valid && ls_req_ready;
      if (gl) begin
        rq.push_back('{cyc + LAT + 1, 1'b1, !ls_we, ref_mem[ls_addr[7:2]]});
        if (ls_we)
          for (int b = 0; b < 4; b++)
            if (ls_wstrb[b]) ref_mem[ls_addr[7:2]][8*b +: 8] = ls_wdata[8*b +: 8];
        if (if_req_valid && starve < SMAX) starve++;
        free_at = cyc + LAT + 1;
        m_lsg++;
      end else if (gi) begin
        rq.push_back('{cyc + LAT + 1, 1'b0, 1'b1, ref_mem[if_addr[7:2]]});
        starve  = 0;
        free_at = cyc + LAT + 1;
        m_ifg++;
      end
      if (idle && if_req_valid && ls_req_valid) m_conf++;
      if (rst) begin
        starve     = 0;
        free_at    = cyc + 1;
        rq.delete();
        e_if_rdata = '0;
        e_ls_rdata = '0;
        m_ifg = '0; m_lsg = '0; m_conf = '0;
        armed = 1'b1;
      end
    end
  end

  task automatic issue(input bit is_ls, input logic [31:0] addr, input bit we,
                       input logic [3:0] strb, input logic [31:0] wd, output int t);
    @(posedge clk); #1;
    if (is_ls) begin
      ls_req_valid = 1'b1; ls_addr = addr; ls_we = we; ls_wstrb = strb; ls_wdata = wd;
    end else begin
      if_req_valid = 1'b1; if_addr = addr;
    end
    t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (is_ls ? ls_req_ready : if_req_ready) begin
        t = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    if (is_ls) ls_req_valid = 1'b0;
    else if_req_valid = 1'b0;
    if (t < 0) check(is_ls ? "ls_accept_timeout" : "if_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(input bit is_ls, output int t, output logic [31:0] d);
    t = -1;
    d = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (is_ls ? ls_rsp_valid : if_rsp_valid) begin
        t = cyc;
        d = is_ls ? ls_rdata : if_rdata;
        break;
      end
    end
    if (t < 0) check(is_ls ? "ls_rsp_timeout" : "if_rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int          ta, tr;
    logic [31:0] d;
    bit          seq[$];
    bit          exp_seq [10];
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_we = 1'b0; ls_wstrb = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch of the instruction at 0x10.
    issue(1'b0, 32'h10, 1'b0, 4'h0, 32'h0, ta);
    wait_rsp(1'b0, tr, d);
    check("fetch_rsp_latency", 64'(tr - ta), 64'(LAT + 1));
    check("fetch_rdata", d, 32'h0050_0093);

    // Load, store, load back; a store response leaves ls_rdata untouched.
    issue(1'b1, 32'h44, 1'b0, 4'h0, 32'h0, ta);
    wait_rsp(1'b1, tr, d);
    check("load44_rdata", d, 32'h1000_0011);
    issue(1'b1, 32'h40, 1'b1, 4'hF, 32'hDEAD_BEEF, ta);
    wait_rsp(1'b1, tr, d);
    check("store_rsp_latency", 64'(tr - ta), 64'(LAT + 1));
    check("store_keeps_ls_rdata", d, 32'h1000_0011);
    issue(1'b1, 32'h40, 1'b0, 4'h0, 32'h0, ta);
    wait_rsp(1'b1, tr, d);
    check("load40_rdata", d, 32'hDEAD_BEEF);

    // Reset during the wait window discards the access; a re-issue completes normally.
    issue(1'b1, 32'h44, 1'b0, 4'h0, 32'h0, ta);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check("rst_drops_rsp", ls_rsp_valid, 1'b0);
    end
    check("rst_clears_ls_rdata", ls_rdata, 32'h0);
    issue(1'b1, 32'h44, 1'b0, 4'h0, 32'h0, ta);
    wait_rsp(1'b1, tr, d);
    check("reissue_latency", 64'(tr - ta), 64'(LAT + 1));
    check("reissue_rdata", d, 32'h1000_0011);

    // Busy window: no ready while waiting, next accept allowed in the response cycle.
    issue(1'b1, 32'h48, 1'b0, 4'h0, 32'h0, ta);
    if_req_valid = 1'b1; if_addr = 32'h10;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check("busy_if_ready_low", if_req_ready, 1'b0);
      check("busy_no_ls_rsp", ls_rsp_valid, 1'b0);
    end
    @(negedge clk);
    check("rsp_cycle_offset", 64'(cyc - ta), 64'(LAT + 1));
    check("ls_rsp_pulse", ls_rsp_valid, 1'b1);
    check("ls_rdata_48", ls_rdata, 32'h1000_0012);
    check("accept_in_rsp_cycle", if_req_ready, 1'b1);
    @(posedge clk); #1 if_req_valid = 1'b0;
    @(negedge clk);
    check("ls_rsp_one_cycle", ls_rsp_valid, 1'b0);
    wait_rsp(1'b0, tr, d);
    check("fetch_after_load", d, 32'h0050_0093);

    // Both ports requesting continuously: starvation guard forces fetch every fifth grant.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h10;
    ls_req_valid = 1'b1; ls_addr = 32'h44; ls_we = 1'b0;
    for (int k = 0; k < 200 && seq.size() < 10; k++) begin
      @(negedge clk); #1;
      if (if_req_ready) seq.push_back(1'b0);
      if (ls_req_ready) seq.push_back(1'b1);
      @(posedge clk); #1;
      if (seq.size() >= 10) begin
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
      end
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    check("grant_count", 64'(seq.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      if (i < seq.size()) check($sformatf("grant_%0d_is_ls", i), seq[i], exp_seq[i]);
    repeat (LAT + 3) @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    check("perf_if_grants", if_grant_cnt, 32'd2);
    check("perf_ls_grants", ls_grant_cnt, 32'd8);
    check("perf_conflicts", conflict_cnt, 32'd10);
`endif

    // Randomized traffic with occasional resets; requesters hold until accepted.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 249) == 0);
      if (!if_req_valid || if_acc) begin
        if_req_valid = ($urandom_range(0, 1) == 1);
        if_addr      = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!ls_req_valid || ls_acc) begin
        ls_req_valid = ($urandom_range(0, 2) != 0);
        ls_addr      = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        ls_we        = ($urandom_range(0, 1) == 1);
        ls_wstrb     = 4'($urandom_range(0, 15));
        ls_wdata     = $urandom;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
